// File: rtl/fan_controller_if.sv
// Wishbone slave bus bundle for the fan controller register file.
interface fan_controller_if;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic        wb_we_i;
  logic [15:0] wb_adr_i;
  logic [15:0] wb_dat_i;
  logic [15:0] wb_dat_o;
  logic        wb_ack_o;

  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i,
    input  wb_dat_o, wb_ack_o
  );

  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i,
    output wb_dat_o, wb_ack_o
  );
endinterface

// File: rtl/fan_controller.sv
// Three-channel PWM fan controller with a Wishbone register file.
// Duty changes take effect at the PWM period boundary; enable/force act immediately.
module fan_controller #(
  parameter int unsigned PWM_PRESCALE = 16,
  parameter logic [7:0]  DEFAULT_DUTY = 8'hC0
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  fan_controller_if.slave wb,
  output logic [2:0]      fan_control
);

  localparam int unsigned PW = 16;
  localparam int unsigned DW = 8;
  localparam int unsigned NF = 3;
  localparam int unsigned BW = 16;
  localparam logic [PW-1:0] PRESC_MAX = PW'(PWM_PRESCALE - 1);

  logic [PW-1:0]        presc_q, presc_d;
  logic [DW-1:0]        cnt_q, cnt_d;
  logic [NF-1:0][DW-1:0] duty_q, duty_d;
  logic [NF-1:0][DW-1:0] shadow_q, shadow_d;
  logic [NF-1:0]        en_q, en_d;
  logic                 ff_q, ff_d;
  logic                 ack_q, ack_d;
  logic [BW-1:0]        dat_q, dat_d;
  logic [NF-1:0]        fan_q, fan_d;

  logic                 tick_c;
  logic                 wrap_c;
  logic                 access_c;
  logic [BW-1:0]        rd_val_c;
  logic [NF-1:0]        raw_c;
  logic                 unused_bits;

  assign unused_bits = ^{wb.wb_adr_i[15:2], wb.wb_dat_i[15:8]};

  // Timebase, register file and PWM compare.
  always_comb begin
    presc_d  = presc_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    duty_d   = duty_q;
    en_d     = en_q;
    ff_d     = ff_q;
    rd_val_c = '0;
    raw_c    = '0;

    tick_c   = (presc_q == PRESC_MAX);
    wrap_c   = tick_c && (cnt_q == 8'hFF);
    access_c = wb.wb_cyc_i & wb.wb_stb_i & ~ack_q;

    presc_d = tick_c ? '0 : presc_q + PW'(1);
    if (tick_c) cnt_d = cnt_q + DW'(1);
    // Shadows take the pre-write duty value so a write on the wrap edge lands one period later.
    if (wrap_c) shadow_d = duty_q;

    if (access_c && wb.wb_we_i) begin
      if (wb.wb_adr_i[1:0] == 2'd3) begin
        en_d = wb.wb_dat_i[2:0];
        ff_d = wb.wb_dat_i[3];
      end else begin
        for (int unsigned i = 0; i < NF; i++) begin
          if (wb.wb_adr_i[1:0] == 2'(i)) duty_d[i] = wb.wb_dat_i[DW-1:0];
        end
      end
    end

    if (wb.wb_adr_i[1:0] == 2'd3) begin
      rd_val_c = {12'b0, ff_d, en_d};
    end else begin
      for (int unsigned i = 0; i < NF; i++) begin
        if (wb.wb_adr_i[1:0] == 2'(i)) rd_val_c = {8'b0, duty_d[i]};
      end
    end

    for (int unsigned i = 0; i < NF; i++) begin
      raw_c[i] = (shadow_q[i] == 8'hFF) || (cnt_q < shadow_q[i]);
    end
  end

  assign ack_d = access_c;
  assign dat_d = access_c ? rd_val_c : '0;
  assign fan_d = en_q & ({NF{ff_q}} | raw_c);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      presc_q  <= '0;
      cnt_q    <= '0;
      duty_q   <= {NF{DEFAULT_DUTY}};
      shadow_q <= {NF{DEFAULT_DUTY}};
      en_q     <= '1;
      ff_q     <= 1'b0;
      ack_q    <= 1'b0;
      dat_q    <= '0;
      fan_q    <= '0;
    end else begin
      presc_q  <= presc_d;
      cnt_q    <= cnt_d;
      duty_q   <= duty_d;
      shadow_q <= shadow_d;
      en_q     <= en_d;
      ff_q     <= ff_d;
      ack_q    <= ack_d;
      dat_q    <= dat_d;
      fan_q    <= fan_d;
    end
  end

  assign wb.wb_ack_o = ack_q;
  assign wb.wb_dat_o = dat_q;
  assign fan_control = fan_q;

endmodule

// File: tb/tb_fan_controller.sv
// Randomized scoreboard bench for fan_controller against a time-indexed PWM model.
module tb_fan_controller;

  localparam int P      = 2;
  localparam int PERIOD = 256 * P;

  typedef struct packed {
    logic [2:0]  fan;
    logic        ack;
    logic [15:0] dat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [2:0] fan_control;
  fan_controller_if bus ();

  fan_controller #(.PWM_PRESCALE(P), .DEFAULT_DUTY(8'hC0)) dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .wb         (bus.slave),
    .fan_control(fan_control)
  );

  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;
  exp_t exp_q[$];

  // Model state: register file, per-period duty and elapsed cycles since reset release.
  logic [7:0] m_duty [3];
  logic [7:0] m_active [3];
  logic [2:0] m_en;
  logic       m_ff;
  logic       m_ack;
  int         n;
  int         pos, step;
  logic       acc, raw;
  exp_t       e;

  always @(posedge clk) begin
    e = '0;
    if (rst) begin
      for (int i = 0; i < 3; i++) begin m_duty[i] = 8'hC0; m_active[i] = 8'hC0; end
      m_en = 3'b111; m_ff = 1'b0; m_ack = 1'b0; n = 0;
    end else begin
      pos  = n % PERIOD;
      step = pos / P;
      for (int i = 0; i < 3; i++) begin
        raw = (m_active[i] == 8'hFF) || (step < int'(m_active[i]));
        e.fan[i] = m_en[i] & (m_ff | raw);
      end
      if (pos == PERIOD - 1)
        for (int i = 0; i < 3; i++) m_active[i] = m_duty[i];
      acc = bus.wb_cyc_i & bus.wb_stb_i & ~m_ack;
      if (acc && bus.wb_we_i) begin
        if (bus.wb_adr_i[1:0] == 2'd3) begin
          m_en = bus.wb_dat_i[2:0]; m_ff = bus.wb_dat_i[3];
        end else begin
          m_duty[bus.wb_adr_i[1:0]] = bus.wb_dat_i[7:0];
        end
      end
      e.ack = acc;
      if (acc) begin
        if (bus.wb_adr_i[1:0] == 2'd3) e.dat = {12'b0, m_ff, m_en};
        else e.dat = {8'b0, m_duty[bus.wb_adr_i[1:0]]};
      end
      m_ack = acc;
      n = n + 1;
    end
    exp_q.push_back(e);
  end

  // Monitor: compare every presented output against the queued expectation.
  always @(negedge clk) begin
    exp_t x;
    if (exp_q.size() > 0) begin
      x = exp_q.pop_front();
      vectors++;
      if (fan_control !== x.fan) begin
        miscompares++;
        if (miscompares < 20) $display("FAIL fan t=%0t got %b want %b", $time, fan_control, x.fan);
      end
      vectors++;
      if (bus.wb_ack_o !== x.ack) begin
        miscompares++;
        if (miscompares < 20) $display("FAIL ack t=%0t got %b want %b", $time, bus.wb_ack_o, x.ack);
      end
      vectors++;
      if (bus.wb_dat_o !== x.dat) begin
        miscompares++;
        if (miscompares < 20) $display("FAIL dat t=%0t got %h want %h", $time, bus.wb_dat_o, x.dat);
      end
    end
  end

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) @(negedge clk);
  endtask

  // Called at a negedge; returns at the negedge of the ack cycle (or after timeout).
  task automatic bus_xfer(input logic we, input logic [1:0] adr, input logic [15:0] dat);
    bit got = 1'b0;
    bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = we;
    bus.wb_adr_i = {$urandom_range(0, 16383), adr};
    bus.wb_dat_i = dat;
    for (int i = 0; i < 4 && !got; i++) begin
      @(negedge clk);
      got = bus.wb_ack_o;
    end
    vectors++;
    if (!got) begin
      miscompares++;
      $display("FAIL ack_timeout adr=%0d got no ack want ack within 4 cycles", adr);
    end
    bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0;
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    idle(cycles);
    rst = 1'b0;
  endtask

  initial begin
    bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0;
    bus.wb_adr_i = '0;   bus.wb_dat_i = '0;
    @(negedge clk);
    do_reset(20);

    // Reset readback of all four registers.
    for (int a = 0; a < 4; a++) begin bus_xfer(1'b0, 2'(a), 16'h0); idle(1); end

    // Free-running default pattern over many periods.
    idle(48 * PERIOD);

    // Fan 1 to zero mid-period, fan 2 to full.
    idle(PERIOD / 3);
    bus_xfer(1'b1, 2'd1, 16'h0000);
    idle(2 * PERIOD);
    bus_xfer(1'b1, 2'd2, 16'h00FF);
    idle(2 * PERIOD);

    // Enable/force take effect immediately.
    bus_xfer(1'b1, 2'd3, 16'h0008);
    idle(5);
    bus_xfer(1'b1, 2'd3, 16'h000F);
    idle(5);
    bus_xfer(1'b1, 2'd3, 16'h0007);

    // Duty write landing exactly on the wrap edge.
    for (int i = 0; i < PERIOD + 2 && (n % PERIOD) != PERIOD - 1; i++) @(negedge clk);
    bus_xfer(1'b1, 2'd0, 16'h0040);
    idle(2 * PERIOD);

    // Randomized register traffic.
    for (int k = 0; k < 120; k++) begin
      bus_xfer(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 16'($urandom));
      idle($urandom_range(0, 300));
    end

    // Reset mid-transfer with modified registers, then resume default pattern.
    bus_xfer(1'b1, 2'd0, 16'h0010);
    idle(37);
    bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = 1'b1;
    bus.wb_adr_i = 16'd2; bus.wb_dat_i = 16'h0001;
    rst = 1'b1;
    idle(1);
    bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0;
    idle(4);
    rst = 1'b0;
    for (int a = 0; a < 4; a++) begin bus_xfer(1'b0, 2'(a), 16'h0); idle(1); end
    idle(3 * PERIOD);

    idle(3);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fan_controller.md
FAN_CONTROLLER -- requirements
Module: fan_controller

Interface
REQ-001 Parameter PWM_PRESCALE, default 16, meaning clock cycles per PWM step (legal range 1..65535).
REQ-002 Parameter DEFAULT_DUTY, default 8'hC0, meaning per-fan duty loaded at reset.
REQ-003 wb_clk_i  input  1  system clock; sole clock; all logic on its rising edge.
REQ-004 wb_rst_i  input  1  synchronous, active-high reset.
REQ-005 wb_cyc_i  input  1  Wishbone cycle.
REQ-006 wb_stb_i  input  1  Wishbone strobe.
REQ-007 wb_we_i  input  1  Wishbone write enable.
REQ-008 wb_adr_i  input  16  word address; only bits [1:0] decoded.
REQ-009 wb_dat_i  input  16  write data.
REQ-010 wb_dat_o  output  16  read data.
REQ-011 wb_ack_o  output  1  transfer acknowledge.
REQ-012 fan_control  output  3  active-high PWM drive, bit i = fan i.

Function
REQ-013 Register map: adr 0/1/2 = DUTY0/1/2 (bits [7:0], RW); adr 3 = CTRL (bit[2:0] ENABLE per fan, bit[3] FORCE_FULL, RW); unused bits read 0, ignored on write.
REQ-014 Access = wb_cyc_i & wb_stb_i & ~wb_ack_o; wb_ack_o asserts one cycle after access, lasts exactly one cycle, then deasserts.
REQ-015 Write commits on the access cycle; wb_dat_o holds the addressed register value in the ack cycle, 0 otherwise.
REQ-016 Prescaler counts 0..PWM_PRESCALE-1 and wraps; a tick occurs in the cycle it equals PWM_PRESCALE-1.
REQ-017 8-bit PWM counter increments on each tick, wraps 255->0; PWM period = 256*PWM_PRESCALE cycles (4096 by default).
REQ-018 Each fan has an active-duty shadow register, loaded from DUTYi on the tick where the PWM counter wraps 255->0; writes never change a period in progress.
REQ-019 Raw drive i = (active_duty_i == 255) | (pwm_cnt < active_duty_i); duty 0 = always low, 255 = always high, else high for active_duty_i steps per period.
REQ-020 fan_control[i] registered = ENABLE[i] & (FORCE_FULL | raw drive i); one cycle latency from counter state.
REQ-021 FORCE_FULL and ENABLE changes act on the next clock edge (not deferred to period boundary).
REQ-022 Simultaneous DUTY write and period wrap: shadow loads the old value; new value used from the following period.

Reset
REQ-023 In any cycle with wb_rst_i=1: prescaler=0, pwm_cnt=0, DUTY0..2 and shadows = DEFAULT_DUTY, ENABLE=3'b111, FORCE_FULL=0, fan_control=3'b000, wb_ack_o=0, wb_dat_o=0.
REQ-024 Reset asserted mid-period or mid-transfer aborts immediately; pending ack is dropped; first PWM period starts cleanly after release.
REQ-025 After reset release with defaults, fan_control goes 3'b111 within 2 cycles.

Verification
REQ-026 Reset 20 cycles, release, no bus traffic -> each fan high 3072 cycles, low 1024 cycles, period 4096, all three in phase, for at least 48 periods.
REQ-027 Write DUTY1=0x00 mid-period -> fan 1 unchanged until next wrap, then constantly low; fans 0/2 unaffected.
REQ-028 Write DUTY2=0xFF -> fan 2 constantly high from next period, no low glitch at wrap.
REQ-029 Write CTRL=0x8 (ENABLE=000, FORCE_FULL=1) -> all outputs low next cycle; then CTRL=0xF -> all high next cycle regardless of pwm_cnt.
REQ-030 Read adr 0..3 after reset -> 0x00C0, 0x00C0, 0x00C0, 0x0007; each with single-cycle ack one cycle after strobe.
REQ-031 Assert wb_rst_i during a period with modified registers -> outputs 0 in reset, registers return to REQ-023 values, REQ-026 pattern resumes.
